// File: rtl/loader_pkg.sv
// Shared definitions for the nibble-stream loader and the frame collector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package loader_pkg;

    // Frame assembly state.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Rejection cause reported on err_code.
    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_SHORT = 2'b01,
        ERR_LONG  = 2'b10,
        ERR_MODE  = 2'b11
    } err_t;

    // Bit-field positions inside the upstream byte.
    localparam int MODE_HI = 7;
    localparam int MODE_LO = 5;
    localparam int RDY_BIT = 4;
    localparam int NIB_HI  = 3;
    localparam int NIB_LO  = 0;

endpackage

// File: rtl/frame_collector.sv
// Assembles two W-bit words from a nibble stream into a one-deep hold register.
// Latency: held frame visible 1 cycle after the first rdy=0 byte; errors pulse 1 cycle after detection.
// Backpressure: out_valid/out_ready; a good frame arriving while the hold is full and not draining is dropped with an overrun pulse.
//
// Ports:
//   clk, rst             clock (rising edge) and asynchronous active-high reset
//   in_byte[7:0]         {mode[2:0], rdy, nibble[3:0]}
//   out_ready            downstream accepts the held frame
//   out_valid/out_mode/out_word_a/out_word_b   held frame
//   frame_err, err_code  rejection pulse and sticky cause
//   overrun              pulse when a good frame is dropped
//   busy                 state is not IDLE
module frame_collector
    import loader_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_byte,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [2:0]   out_mode,
    output logic [W-1:0] out_word_a,
    output logic [W-1:0] out_word_b,
    output logic         frame_err,
    output logic [1:0]   err_code,
    output logic         overrun,
    output logic         busy
);

    localparam int NIB = W / 4;
    localparam int CW  = $clog2(2 * NIB + 1);
    localparam logic [CW-1:0] HALF = CW'(NIB);
    localparam logic [CW-1:0] FULL = CW'(2 * NIB);

    logic [2:0] in_mode;
    logic       in_rdy;
    logic [3:0] in_nib;

    assign in_mode = in_byte[MODE_HI:MODE_LO];
    assign in_rdy  = in_byte[RDY_BIT];
    assign in_nib  = in_byte[NIB_HI:NIB_LO];

    state_t        state;
    logic [CW-1:0] count;
    logic [2:0]    mode_q;
    logic [W-1:0]  a_sr;
    logic [W-1:0]  b_sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            count      <= '0;
            mode_q     <= '0;
            a_sr       <= '0;
            b_sr       <= '0;
            out_valid  <= 1'b0;
            out_mode   <= '0;
            out_word_a <= '0;
            out_word_b <= '0;
            frame_err  <= 1'b0;
            err_code   <= ERR_NONE;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            // Handshake clears the hold; a good frame loading below overrides this.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            unique case (state)
                S_IDLE: begin
                    if (in_rdy) begin
                        mode_q <= in_mode;
                        a_sr   <= {a_sr[W-5:0], in_nib};
                        count  <= CW'(1);
                        state  <= S_RECV;
                        busy   <= 1'b1;
                    end
                end

                S_RECV: begin
                    if (in_rdy) begin
                        // A mode change outranks the length check.
                        if (in_mode != mode_q) begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_MODE;
                            state     <= S_DRAIN;
                        end else if (count == FULL) begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_LONG;
                            state     <= S_DRAIN;
                        end else begin
                            // count is the number of nibbles already taken.
                            if (count < HALF) begin
                                a_sr <= {a_sr[W-5:0], in_nib};
                            end else begin
                                b_sr <= {b_sr[W-5:0], in_nib};
                            end
                            count <= count + CW'(1);
                        end
                    end else begin
                        state <= S_IDLE;
                        count <= '0;
                        busy  <= 1'b0;
                        if (count == FULL) begin
                            if (!out_valid || out_ready) begin
                                out_valid  <= 1'b1;
                                out_mode   <= mode_q;
                                out_word_a <= a_sr;
                                out_word_b <= b_sr;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_SHORT;
                        end
                    end
                end

                S_DRAIN: begin
                    if (!in_rdy) begin
                        state <= S_IDLE;
                        count <= '0;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    count <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/frame_collector.md
FRAME_COLLECTOR -- requirements
Module: frame_collector

Interface
REQ-001 SHALL have parameter W, default 32, meaning word width in bits (multiple of 4); NIB = W/4 nibbles per word.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_byte  input  8  upstream byte: [7:5] mode, [4] rdy, [3:0] nibble.
REQ-005 SHALL have port out_ready  input  1  downstream accepts the held frame.
REQ-006 SHALL have port out_valid  output  1  a held frame is available.
REQ-007 SHALL have port out_mode  output  3  mode of the held frame.
REQ-008 SHALL have port out_word_a  output  W  first word of the held frame.
REQ-009 SHALL have port out_word_b  output  W  second word of the held frame.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse when a frame is rejected.
REQ-011 SHALL have port err_code  output  2  cause of the last rejection: 00 none, 01 short, 10 long, 11 mode change; holds until the next rejection.
REQ-012 SHALL have port overrun  output  1  one-cycle pulse when a good frame is dropped because the hold register is full.
REQ-013 SHALL have port busy  output  1  high while the state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, RECV, DRAIN.
REQ-015 IDLE: on rdy=1, SHALL latch mode, store the nibble as nibble 1, set count=1, and go to RECV; the byte is ignored while rdy=0.
REQ-016 RECV with rdy=1 and count<2*NIB: SHALL shift the nibble in, MSB-first. Nibbles 1..NIB form word A and nibbles NIB+1..2*NIB form word B. Count SHALL increment.
REQ-017 RECV with rdy=1 and a mode different from the latched mode: SHALL reject the frame with code 11 and go to DRAIN.
REQ-018 RECV with rdy=1 and count=2*NIB: SHALL reject the frame with code 10 and go to DRAIN.
REQ-019 RECV with rdy=0: count=2*NIB is a good frame and count<2*NIB is rejected with code 01; both cases SHALL return to IDLE.
REQ-020 DRAIN: SHALL ignore input until rdy=0, then go to IDLE; no further errors SHALL be raised for that frame.
REQ-021 A rejection SHALL pulse frame_err for exactly one cycle, in the cycle after the detecting edge; the hold register SHALL be unchanged.
REQ-022 A good frame SHALL load the hold register and set out_valid on the edge that detects rdy=0, so out_valid is visible 1 cycle after the first rdy=0 byte.
REQ-023 Handshake: the held frame transfers on a cycle with out_valid=1 and out_ready=1. out_valid SHALL clear after the transfer unless a new good frame loads on the same edge.
REQ-024 Good frame while out_valid=1 and out_ready=0: SHALL keep the old frame, drop the new one, and pulse overrun for one cycle.
REQ-025 Good frame while out_valid=1 and out_ready=1: SHALL transfer the old frame and load the new one; out_valid stays 1 and overrun SHALL NOT assert.
REQ-026 Held outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-027 A rdy=1 byte in the cycle that returns to IDLE SHALL NOT be captured; a new frame starts only from IDLE.
REQ-028 The count width SHALL be clog2(2*NIB+1) bits; the count SHALL never wrap.

Reset
REQ-029 rst SHALL asynchronously force: state IDLE, count 0, out_valid 0, out_mode 0, out_word_a 0, out_word_b 0, frame_err 0, err_code 00, overrun 0, busy 0.
REQ-030 Reset mid-frame SHALL discard the partial frame and any held frame; the first rdy=1 byte after release SHALL start a new frame.

Structure
REQ-031 The state enum, the error-code enum (ERR_NONE, ERR_SHORT, ERR_LONG, ERR_MODE) and the bit-field positions of in_byte SHALL live in a shared package, loader_pkg, which is also used by the upstream loader.
REQ-032 The block SHALL be a single module with no sub-modules; A and B SHALL be shift registers of width W.

Verification
REQ-033 W=32: mode=5, 16 rdy bytes carrying DEADBEEF then 12345678, then rdy=0 -> 1 cycle later out_valid=1, out_mode=5, out_word_a=0xDEADBEEF, out_word_b=0x12345678, frame_err=0.
REQ-034 Same frame with only 15 nibbles -> frame_err pulse, err_code=01, out_valid stays 0, busy=0 one cycle later.
REQ-035 17 rdy bytes -> frame_err pulse and err_code=10 on the 17th byte; state stays DRAIN until rdy=0; no out_valid.
REQ-036 Mode changes 5->3 at nibble 9 -> err_code=11, DRAIN; a following clean frame with mode=3 is accepted.
REQ-037 Two good frames with out_ready=0 -> first frame held, overrun pulses once. Repeat with out_ready=1 at the second frame's end -> both frames transfer and no overrun.
REQ-038 rst pulse after nibble 6 with out_valid=1 -> all outputs 0 immediately; the next full frame is received correctly.
